// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath.
// Holds the datapath/state widths, encodings of the controller
// select fields (ALU_Op, ALU_srcB, PC_Source), the R-type funct codes
// decoded by the ALU, and the immediate sign-extension helper.
package mc_pkg;

    localparam int DATA_W  = 32;
    localparam int STATE_W = 4;
    localparam int REG_AW  = 5;

    typedef enum logic [1:0] {
        ALU_OP_ADD     = 2'b00,
        ALU_OP_SUB     = 2'b01,
        ALU_OP_FUNCT   = 2'b10,
        ALU_OP_ADD_ALT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU     = 2'b00,
        PCSRC_ALUOUT  = 2'b01,
        PCSRC_JUMP    = 2'b10,
        PCSRC_ALU_ALT = 2'b11
    } pc_src_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    function automatic logic [DATA_W-1:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32 x 32 register file, two combinational read ports, one write port.
// Register $0 is hardwired to zero: writes to it are dropped and reads
// return 0. Reset clears every register.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_raddr1/2        read addresses
//   o_rdata1/2        read data (combinational, pre-write value on a same-edge write)
//   i_we, i_waddr,
//   i_wdata           write enable, address and data (applied on rising edge)
module reg_file
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath plus controller state register.
// Executes the control word supplied each cycle by the external
// controller, holding PC, IR, MDR, A, B, ALUOut, the 4-bit state and a
// 32x32 register file, and drives one shared instruction/data memory port.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   next_state / state     controller next state in, registered state out
//   PC_write ... Reg_Dst   single-bit control inputs
//   PC_Source, ALU_Op,
//   ALU_srcB               2-bit control selects
//   opcode                 IR[31:26]
//   mem_addr, mem_wdata,
//   mem_read, mem_write,
//   mem_rdata              memory port (asynchronous read data)
//   zero                   ALU result equals zero
module multicycle_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] next_state,
    input  logic               PC_write,
    input  logic               PC_write_cond,
    input  logic               IorD,
    input  logic               Mem_Read,
    input  logic               Mem_Write,
    input  logic               IR_Write,
    input  logic               Mem_To_Reg,
    input  logic               ALU_srcA,
    input  logic               Reg_Write,
    input  logic               Reg_Dst,
    input  logic [1:0]         PC_Source,
    input  logic [1:0]         ALU_Op,
    input  logic [1:0]         ALU_srcB,
    output logic [STATE_W-1:0] state,
    output logic [5:0]         opcode,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_read,
    output logic               mem_write,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               zero
);

    logic [STATE_W-1:0] r_state;
    logic [DATA_W-1:0]  r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;

    logic [DATA_W-1:0]  w_rd1, w_rd2, w_imm;
    logic [DATA_W-1:0]  w_alu_a, w_alu_b, w_alu_res, w_pc_next;
    logic [REG_AW-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_pc_en;

    reg_file u_rf (
        .clk      (clk),
        .reset    (reset),
        .i_raddr1 (r_ir[25:21]),
        .i_raddr2 (r_ir[20:16]),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2),
        .i_we     (Reg_Write),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata)
    );

    assign w_imm   = sign_extend16(r_ir[15:0]);
    assign w_waddr = Reg_Dst ? r_ir[15:11] : r_ir[20:16];
    assign w_wdata = Mem_To_Reg ? r_mdr : r_aluout;

    assign w_alu_a = ALU_srcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (ALU_srcB)
            SRCB_B:       w_alu_b = r_b;
            SRCB_FOUR:    w_alu_b = 32'd4;
            SRCB_IMM:     w_alu_b = w_imm;
            SRCB_IMM_SH2: w_alu_b = {w_imm[DATA_W-3:0], 2'b00};
            default:      w_alu_b = r_b;
        endcase
    end

    // Unrecognised funct codes fall back to add so the ALU never idles on X.
    always_comb begin
        w_alu_res = w_alu_a + w_alu_b;
        case (ALU_Op)
            ALU_OP_SUB: w_alu_res = w_alu_a - w_alu_b;
            ALU_OP_FUNCT: begin
                case (r_ir[5:0])
                    FUNCT_SUB: w_alu_res = w_alu_a - w_alu_b;
                    FUNCT_AND: w_alu_res = w_alu_a & w_alu_b;
                    FUNCT_OR:  w_alu_res = w_alu_a | w_alu_b;
                    FUNCT_SLT: w_alu_res = ($signed(w_alu_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
                    default:   w_alu_res = w_alu_a + w_alu_b;
                endcase
            end
            default: w_alu_res = w_alu_a + w_alu_b;
        endcase
    end

    assign zero = (w_alu_res == '0);

    always_comb begin
        w_pc_next = w_alu_res;
        case (PC_Source)
            PCSRC_ALUOUT: w_pc_next = r_aluout;
            PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            default:      w_pc_next = w_alu_res;
        endcase
    end

    assign w_pc_en = PC_write | (PC_write_cond & zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= '0;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            r_state  <= next_state;
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (IR_Write) begin
                r_ir <= mem_rdata;
            end
            r_mdr    <= mem_rdata;
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_alu_res;
        end
    end

    assign state     = r_state;
    assign opcode    = r_ir[31:26];
    assign mem_addr  = IorD ? r_aluout : r_pc;
    assign mem_wdata = r_b;
    assign mem_read  = Mem_Read;
    assign mem_write = Mem_Write;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  next_state;
    logic        PC_write, PC_write_cond, IorD, Mem_Read, Mem_Write, IR_Write;
    logic        Mem_To_Reg, ALU_srcA, Reg_Write, Reg_Dst;
    logic [1:0]  PC_Source, ALU_Op, ALU_srcB;
    logic [3:0]  state;
    logic [5:0]  opcode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, zero;

    logic [31:0] mem [0:63];
    logic [31:0] exp_pc;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .next_state(next_state),
        .PC_write(PC_write), .PC_write_cond(PC_write_cond), .IorD(IorD),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .Mem_To_Reg(Mem_To_Reg), .ALU_srcA(ALU_srcA), .Reg_Write(Reg_Write),
        .Reg_Dst(Reg_Dst), .PC_Source(PC_Source), .ALU_Op(ALU_Op),
        .ALU_srcB(ALU_srcB), .state(state), .opcode(opcode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .zero(zero)
    );

    // Classic multicycle controller control words, keyed by state.
    task automatic drive(input logic [3:0] s, input logic [3:0] nxt);
        PC_write = 0; PC_write_cond = 0; IorD = 0; Mem_Read = 0; Mem_Write = 0;
        IR_Write = 0; Mem_To_Reg = 0; ALU_srcA = 0; Reg_Write = 0; Reg_Dst = 0;
        PC_Source = 2'b00; ALU_Op = 2'b00; ALU_srcB = 2'b00;
        case (s)
            4'd0: begin Mem_Read = 1; IR_Write = 1; ALU_srcB = 2'b01; PC_write = 1; end
            4'd1: begin ALU_srcB = 2'b11; end
            4'd2: begin ALU_srcA = 1; ALU_srcB = 2'b10; end
            4'd3: begin Mem_Read = 1; IorD = 1; end
            4'd4: begin Reg_Write = 1; Mem_To_Reg = 1; end
            4'd5: begin Mem_Write = 1; IorD = 1; end
            4'd6: begin ALU_srcA = 1; ALU_Op = 2'b10; end
            4'd7: begin Reg_Dst = 1; Reg_Write = 1; end
            4'd8: begin ALU_srcA = 1; ALU_Op = 2'b01; PC_write_cond = 1; PC_Source = 2'b01; end
            4'd9: begin PC_write = 1; PC_Source = 2'b10; end
            default: ;
        endcase
        next_state = nxt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] nxt);
        drive(s, nxt);
        tick();
    endtask

    task automatic do_reset;
        drive(4'd15, 4'd0);
        reset = 1;
        tick();
        reset = 0;
        exp_pc = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [3:0] after);
        mem[exp_pc[7:2]] = instr;
        step(4'd0, 4'd1);
        exp_pc = exp_pc + 4;
        step(4'd1, after);
    endtask

    task automatic run_lw(input logic [31:0] instr);
        fetch(instr, 4'd2);
        step(4'd2, 4'd3);
        step(4'd3, 4'd4);
        step(4'd4, 4'd0);
    endtask

    task automatic run_r(input logic [31:0] instr);
        fetch(instr, 4'd6);
        step(4'd6, 4'd7);
        step(4'd7, 4'd0);
    endtask

    task automatic test_reset;
        next_state = 4'd7;
        do_reset();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (dut.r_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", dut.r_pc); end
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_B got=%h exp=0", mem_wdata); end
        checks++; if (dut.u_rf.r_regs[5] !== 32'h0) begin errors++; $display("FAIL reset_reg5 got=%h exp=0", dut.u_rf.r_regs[5]); end
    endtask

    task automatic test_lw;
        mem[0] = 32'h8C09_0004;
        mem[1] = 32'hDEAD_BEEF;
        step(4'd0, 4'd1);
        checks++; if (dut.r_pc !== 32'h4) begin errors++; $display("FAIL lw_pc got=%h exp=4", dut.r_pc); end
        checks++; if (opcode !== 6'h23) begin errors++; $display("FAIL lw_opcode got=%h exp=23", opcode); end
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL lw_state1 got=%0d exp=1", state); end
        step(4'd1, 4'd2);
        step(4'd2, 4'd3);
        drive(4'd3, 4'd4);
        #1;
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL lw_mem_addr got=%h exp=4", mem_addr); end
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL lw_mem_read got=%b exp=1", mem_read); end
        tick();
        step(4'd4, 4'd0);
        checks++; if (dut.u_rf.r_regs[9] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_reg9 got=%h exp=deadbeef", dut.u_rf.r_regs[9]); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_state_end got=%0d exp=0", state); end
        exp_pc = 32'h4;
    endtask

    task automatic test_rtype;
        logic [31:0] instrs [5];
        logic [31:0] expv   [5];
        instrs = '{32'h0022_1820, 32'h0022_1822, 32'h0022_1824, 32'h0022_1825, 32'h0022_182A};
        expv   = '{32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7, 32'd1};
        mem[32] = 32'd5;
        mem[33] = 32'd7;
        run_lw(32'h8C01_0080);
        run_lw(32'h8C02_0084);
        for (int k = 0; k < 5; k++) begin
            run_r(instrs[k]);
            checks++;
            if (dut.u_rf.r_regs[3] !== expv[k]) begin
                errors++;
                $display("FAIL rtype_%0d got=%h exp=%h", k, dut.u_rf.r_regs[3], expv[k]);
            end
        end
        checks++; if (dut.r_pc !== 32'd32) begin errors++; $display("FAIL rtype_pc got=%h exp=20", dut.r_pc); end
    endtask

    task automatic test_beq;
        do_reset();
        mem[0] = 32'h0800_0002;
        step(4'd0, 4'd1);
        step(4'd1, 4'd9);
        step(4'd9, 4'd0);
        checks++; if (dut.r_pc !== 32'd8) begin errors++; $display("FAIL beq_setup_pc got=%h exp=8", dut.r_pc); end
        mem[2] = 32'h1021_0003;
        step(4'd0, 4'd1);
        step(4'd1, 4'd8);
        drive(4'd8, 4'd0);
        #1;
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL beq_taken_zero got=%b exp=1", zero); end
        tick();
        checks++; if (dut.r_pc !== 32'd24) begin errors++; $display("FAIL beq_taken_pc got=%h exp=18", dut.r_pc); end

        do_reset();
        mem[32] = 32'd5;
        mem[33] = 32'd7;
        run_lw(32'h8C01_0080);
        run_lw(32'h8C02_0084);
        mem[2] = 32'h1022_0003;
        step(4'd0, 4'd1);
        step(4'd1, 4'd8);
        drive(4'd8, 4'd0);
        #1;
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL beq_nt_zero got=%b exp=0", zero); end
        tick();
        checks++; if (dut.r_pc !== 32'd12) begin errors++; $display("FAIL beq_nt_pc got=%h exp=c", dut.r_pc); end
    endtask

    task automatic test_jump;
        do_reset();
        mem[0] = 32'h0800_0040;
        step(4'd0, 4'd1);
        step(4'd1, 4'd9);
        step(4'd9, 4'd0);
        checks++; if (dut.r_pc !== 32'h100) begin errors++; $display("FAIL jump_pc got=%h exp=100", dut.r_pc); end
        checks++; if (opcode !== 6'h02) begin errors++; $display("FAIL jump_opcode got=%h exp=2", opcode); end
    endtask

    task automatic test_r0_sw;
        do_reset();
        mem[32] = 32'd5;
        run_lw(32'h8C01_0080);
        run_r(32'h0021_0020);
        checks++; if (dut.u_rf.r_regs[0] !== 32'h0) begin errors++; $display("FAIL r0_stored got=%h exp=0", dut.u_rf.r_regs[0]); end
        run_r(32'h0001_2020);
        checks++; if (dut.u_rf.r_regs[4] !== 32'd5) begin errors++; $display("FAIL r0_read got=%h exp=5", dut.u_rf.r_regs[4]); end
        fetch(32'hAC01_0008, 4'd2);
        step(4'd2, 4'd5);
        drive(4'd5, 4'd0);
        #1;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL sw_mem_write got=%b exp=1", mem_write); end
        checks++; if (mem_addr !== 32'd8) begin errors++; $display("FAIL sw_mem_addr got=%h exp=8", mem_addr); end
        checks++; if (mem_wdata !== 32'd5) begin errors++; $display("FAIL sw_mem_wdata got=%h exp=5", mem_wdata); end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        mem[0] = 32'h8C09_0004;
        mem[1] = 32'hDEAD_BEEF;
        step(4'd0, 4'd1);
        step(4'd1, 4'd2);
        drive(4'd2, 4'd3);
        Reg_Write = 1;
        PC_write = 1;
        reset = 1;
        tick();
        reset = 0;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state); end
        checks++; if (dut.r_pc !== 32'h0) begin errors++; $display("FAIL mid_pc got=%h exp=0", dut.r_pc); end
        checks++; if (dut.r_ir !== 32'h0) begin errors++; $display("FAIL mid_ir got=%h exp=0", dut.r_ir); end
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL mid_opcode got=%h exp=0", opcode); end
        checks++; if (dut.u_rf.r_regs[9] !== 32'h0) begin errors++; $display("FAIL mid_reg9 got=%h exp=0", dut.u_rf.r_regs[9]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1;
        exp_pc = 32'h0;
        drive(4'd15, 4'd0);
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_jump();
        test_r0_sw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
